// File: rtl/logic_gate_pkg.sv
// Purpose: shared definitions for the logic gate unit. Holds the operation
// select width and the encodings of the eight bitwise operations.
package logic_gate_pkg;

    localparam int unsigned OP_W = 3;

    typedef logic [OP_W-1:0] op_t;

    localparam op_t OP_AND  = 3'd0;
    localparam op_t OP_OR   = 3'd1;
    localparam op_t OP_XOR  = 3'd2;
    localparam op_t OP_NAND = 3'd3;
    localparam op_t OP_NOR  = 3'd4;
    localparam op_t OP_XNOR = 3'd5;
    localparam op_t OP_NOTA = 3'd6;
    localparam op_t OP_PASS = 3'd7;

endpackage

// File: rtl/logic_gate_core.sv
// Purpose: purely combinational bitwise operator.
// Ports:
//   x   - first operand (WIDTH)
//   y   - second operand (WIDTH)
//   op  - operation select (OP_AND .. OP_PASS)
//   r   - result (WIDTH)
module logic_gate_core
    import logic_gate_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  op_t              op,
    output logic [WIDTH-1:0] r
);

    // All eight codes are defined, so the default arm only serves OP_PASS.
    always_comb begin
        r = x;
        case (op)
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_XOR:  r = x ^ y;
            OP_NAND: r = ~(x & y);
            OP_NOR:  r = ~(x | y);
            OP_XNOR: r = ~(x ^ y);
            OP_NOTA: r = ~x;
            default: r = x;
        endcase
    end

endmodule

// File: rtl/logic_gate_unit.sv
// Purpose: valid/ready wrapper around logic_gate_core with a one-deep output
// register, an optional accumulator feeding back the previous result, and a
// saturating count of accepted beats.
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   in_valid/ready   - operand beat handshake (in_ready is combinational)
//   a, b, op, acc    - operands, operation select, use-accumulator select
//   out_valid/ready  - result handshake
//   c, zero, ones    - registered result and its all-zero / all-one flags
//   cnt              - saturating accepted-beat count
module logic_gate_unit
    import logic_gate_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned ACC_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_t              op,
    input  logic             acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             zero,
    output logic             ones,
    output logic [CNT_W-1:0] cnt
);

    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] r;
    logic             accept;

    // Output slot is free if empty or being drained this cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Accumulator substitution only exists when the mode is built in.
    assign y = ((ACC_EN != 0) && acc) ? acc_reg : b;

    logic_gate_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .x  (a),
        .y  (y),
        .op (op),
        .r  (r)
    );

    // Result register, flags, accumulator and counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            c         <= '0;
            zero      <= 1'b1;
            ones      <= 1'b0;
            acc_reg   <= '0;
            cnt       <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            c         <= r;
            zero      <= (r == '0);
            ones      <= (r == '1);
            acc_reg   <= r;
            if (cnt != '1) begin
                cnt <= cnt + CNT_W'(1);
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_logic_gate_unit.sv
// Self-checking bench for logic_gate_unit (WIDTH=8, CNT_W=4).
module tb_logic_gate_unit;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic [2:0]       op = '0;
    logic             acc = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] c;
    logic             zero;
    logic             ones;
    logic [CNT_W-1:0] cnt;

    int errors = 0;
    int checks = 0;

    // Reference state
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] m_acc = '0;
    int               m_beats = 0;

    // Per-op truth table indexed by {x_bit, y_bit}
    logic [3:0] tt [0:7] = '{4'b1000, 4'b1110, 4'b0110, 4'b0111,
                             4'b0001, 4'b1001, 4'b0011, 4'b1100};

    logic_gate_unit #(
        .WIDTH  (WIDTH),
        .CNT_W  (CNT_W),
        .ACC_EN (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .acc       (acc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .zero      (zero),
        .ones      (ones),
        .cnt       (cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] ref_op(input logic [2:0] o,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] res;
        logic [3:0]       row;
        row = tt[o];
        for (int i = 0; i < int'(WIDTH); i++) begin
            res[i] = row[{x[i], y[i]}];
        end
        return res;
    endfunction

    function automatic int exp_cnt();
        int lim;
        lim = (1 << CNT_W) - 1;
        return (m_beats > lim) ? lim : m_beats;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: compare the presented result with the oldest expected one,
    // pop it when the consumer takes it on the coming edge.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 64'(c), 64'hDEAD);
            end else begin
                chk("c", 64'(c), 64'(exp_q[0]));
                chk("zero", 64'(zero), 64'(exp_q[0] == '0));
                chk("ones", 64'(ones), 64'(exp_q[0] == '1));
                if (out_ready && !rst) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Offer one beat; record its expected result when it will be accepted.
    // Called and returns at posedge+1.
    task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input logic [2:0] top, input logic tacc, input bit rnd_rdy);
        bit done;
        int waited;
        logic [WIDTH-1:0] res;
        a = ta; b = tb; op = top; acc = tacc;
        in_valid = 1'b1;
        done = 0;
        waited = 0;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                res = ref_op(top, ta, tacc ? m_acc : tb);
                exp_q.push_back(res);
                m_acc = res;
                m_beats++;
                done = 1;
            end
            @(posedge clk);
            #1;
            if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
            waited++;
            if (!done && waited > 200) begin
                chk("send_timeout", 64'(waited), 64'(0));
                done = 1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        exp_q.delete();
        m_acc = '0;
        m_beats = 0;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_c", 64'(c), 64'(0));
        chk("rst_zero", 64'(zero), 64'(1));
        chk("rst_ones", 64'(ones), 64'(0));
        chk("rst_cnt", 64'(cnt), 64'(0));
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'(1));
    endtask

    task automatic drain();
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("drain_empty", 64'(exp_q.size()), 64'(0));
        chk("drain_out_valid", 64'(out_valid), 64'(0));
    endtask

    initial begin
        logic [WIDTH-1:0] ta;
        logic [WIDTH-1:0] tb;
        @(posedge clk);
        #1;
        do_reset(2);

        // Truth table, explicit expectations plus the model
        begin
            logic [WIDTH-1:0] tt_exp [0:7] = '{8'h00, 8'hFF, 8'hFF, 8'hFF,
                                                8'h00, 8'h00, 8'hF0, 8'h0F};
            out_ready = 1'b1;
            for (int i = 0; i < 8; i++) begin
                send(8'h0F, 8'hF0, 3'(i), 1'b0, 1'b0);
                chk("tt_c", 64'(c), 64'(tt_exp[i]));
                chk("tt_ones", 64'(ones), 64'(i == 1 || i == 2 || i == 3));
            end
            drain();
            chk("tt_cnt", 64'(cnt), 64'(8));
        end

        // Backpressure
        do_reset(1);
        out_ready = 1'b0;
        send(8'h11, 8'h22, 3'd1, 1'b0, 1'b0);
        fork
            send(8'h01, 8'h03, 3'd0, 1'b0, 1'b0);
            begin
                repeat (3) begin
                    @(posedge clk);
                    #2;
                    chk("bp_in_ready", 64'(in_ready), 64'(0));
                    chk("bp_c_hold", 64'(c), 64'(8'h33));
                end
                out_ready = 1'b1;
            end
        join
        chk("bp_second_c", 64'(c), 64'(8'h01));
        chk("bp_second_valid", 64'(out_valid), 64'(1));
        drain();

        // Accumulate
        do_reset(1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ta = WIDTH'(1 << i);
            send(ta, 8'hAA, 3'd1, 1'b1, 1'b0);
        end
        chk("acc_c", 64'(c), 64'(8'h0F));
        chk("acc_cnt", 64'(cnt), 64'(4));
        drain();

        // Random beats with random backpressure and idle gaps; saturation
        for (int i = 0; i < 40; i++) begin
            ta = WIDTH'($urandom);
            tb = WIDTH'($urandom);
            send(ta, tb, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            #1;
            chk("rand_cnt", 64'(cnt), 64'(exp_cnt()));
        end
        drain();
        chk("sat_cnt", 64'(cnt), 64'(15));

        // Reset mid-stall
        out_ready = 1'b0;
        send(8'h3C, 8'h00, 3'd2, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("stall_valid", 64'(out_valid), 64'(1));
        do_reset(1);
        chk("stall_discard", 64'(out_valid), 64'(0));
        out_ready = 1'b1;
        send(8'h05, 8'h00, 3'd1, 1'b1, 1'b0);
        chk("post_rst_c", 64'(c), 64'(8'h05));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
